// File: rtl/valid_ready_credit_transmitter.sv
// Credit-based transmitter: accepts valid/ready upstream and sends one-cycle
// strobes downstream. Each strobe uses one receiver credit.
module valid_ready_credit_transmitter #(
    parameter int WIDTH   = 8,
    parameter int CREDITS = 4,
    localparam int CREDIT_WIDTH = $clog2(CREDITS + 1)
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [WIDTH-1:0]        write_data,
    input  logic                    write_valid,
    output logic                    write_ready,
    output logic [WIDTH-1:0]        send_data,
    output logic                    send_valid,
    input  logic                    credit_return,
    output logic [CREDIT_WIDTH-1:0] credit_count,
    output logic                    credit_empty,
    output logic                    credit_full,
    output logic                    credit_overflow
);

    localparam logic [CREDIT_WIDTH-1:0] CREDIT_MAX = CREDIT_WIDTH'(CREDITS);
    localparam logic [CREDIT_WIDTH-1:0] CREDIT_ONE = CREDIT_WIDTH'(1);

    logic [CREDIT_WIDTH-1:0] credit_q, credit_d;
    logic [WIDTH-1:0]        send_data_q, send_data_d;
    logic                    send_valid_q, send_valid_d;
    logic                    overflow_q, overflow_d;
    logic                    transfer;

    // Ready depends only on the credit register, so a returned credit at zero
    // only opens the gate on the following cycle.
    assign write_ready = (credit_q != '0);
    assign transfer    = write_valid && write_ready;

    always_comb begin
        credit_d     = credit_q;
        overflow_d   = overflow_q;
        send_valid_d = transfer;
        send_data_d  = transfer ? write_data : send_data_q;
        if (transfer && !credit_return) begin
            credit_d = credit_q - CREDIT_ONE;
        end else if (credit_return && !transfer) begin
            if (credit_q == CREDIT_MAX) begin
                overflow_d = 1'b1;
            end else begin
                credit_d = credit_q + CREDIT_ONE;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            credit_q     <= CREDIT_MAX;
            send_data_q  <= '0;
            send_valid_q <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            credit_q     <= credit_d;
            send_data_q  <= send_data_d;
            send_valid_q <= send_valid_d;
            overflow_q   <= overflow_d;
        end
    end

    assign send_data       = send_data_q;
    assign send_valid      = send_valid_q;
    assign credit_count    = credit_q;
    assign credit_empty    = (credit_q == '0);
    assign credit_full     = (credit_q == CREDIT_MAX);
    assign credit_overflow = overflow_q;

endmodule
